// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared definitions for the memory port arbiter.
//   - ma_state_e : access FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   - REQ_IF / REQ_LS : requester ids, also used as the round-robin history bit
//   - CNT_W : width of the memory latency counter (MEM_LAT up to 15)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_WAIT  = 2'd2,
        MA_DONE  = 2'd3
    } ma_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all requester and memory-side signals of the arbiter.
//   IF side : if_req, if_addr -> if_gnt, if_done
//   LS side : ls_req, ls_we, ls_addr, ls_wdata -> ls_gnt, ls_done
//   shared  : rdata, busy
//   memory  : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modport slave is the arbiter's view; master is the view of the surrounding logic.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_done;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_done, ls_gnt, ls_done, rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_done, ls_gnt, ls_done, rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// mem_port_arbiter_rr_arb2: combinational 2-way round-robin pick.
//   req_i[1:0]  : requests, indexed by requester id (REQ_IF / REQ_LS)
//   last_win_i  : id of the previous winner
//   win_o       : id of the chosen requester (meaningful when valid_o)
//   valid_o     : at least one request present
module mem_port_arbiter_rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_win_i,
    output logic       win_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = req_i[REQ_IF] | req_i[REQ_LS];
        win_o   = REQ_IF;
        if (req_i[REQ_IF] && req_i[REQ_LS]) begin
            // Tie: the requester that did not win last time goes first.
            win_o = ~last_win_i;
        end else if (req_i[REQ_LS]) begin
            win_o = REQ_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and load/store (LS).
//   clk, rst : system clock and synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave carrying both requester handshakes and the memory port
// One access in flight at a time. A grant in IDLE captures the winner's request; ISSUE strobes
// the memory for one cycle; WAIT counts out MEM_LAT cycles and registers read data; DONE pulses
// the winner's done. Round-robin history is updated on every grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    ma_state_e         state_q, state_d;
    logic              last_win_q, last_win_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic arb_win;
    logic arb_valid;

    mem_port_arbiter_rr_arb2 u_rr_arb2 (
        .req_i      ({bus.ls_req, bus.if_req}),
        .last_win_i (last_win_q),
        .win_o      (arb_win),
        .valid_o    (arb_valid)
    );

    always_comb begin
        state_d       = state_q;
        last_win_d    = last_win_q;
        id_d          = id_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        bus.if_gnt    = 1'b0;
        bus.ls_gnt    = 1'b0;
        bus.if_done   = 1'b0;
        bus.ls_done   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = (state_q != MA_IDLE);

        unique case (state_q)
            MA_IDLE: begin
                // Grant is suppressed while rst is high so nothing is captured into a reset.
                if (arb_valid && !rst) begin
                    bus.if_gnt = (arb_win == REQ_IF);
                    bus.ls_gnt = (arb_win == REQ_LS);
                    last_win_d = arb_win;
                    id_d       = arb_win;
                    if (arb_win == REQ_LS) begin
                        we_d    = bus.ls_we;
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end
                    state_d = MA_ISSUE;
                end
            end
            MA_ISSUE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                cnt_d         = CNT_W'(MEM_LAT - 1);
                state_d       = MA_WAIT;
            end
            MA_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = MA_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MA_DONE: begin
                bus.if_done = (id_q == REQ_IF);
                bus.ls_done = (id_q == REQ_LS);
                state_d     = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MA_IDLE;
            last_win_q <= REQ_LS;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT = 1 and 3), each with its own memory model,
// scripted-then-random requesters and a transaction-timing reference model checked every cycle.
module tb_mem_port_arbiter;

    localparam int NCYC = 2000;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'hA5 : 8'(i * 29 + 7);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
        logic rst;

        mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Memory: read data is valid only exactly LAT cycles after mem_en, junk otherwise.
        logic [7:0] mem    [256];
        logic [7:0] refmem [256];
        logic [7:0] pipe_d [LAT];
        logic       pipe_v [LAT];
        logic [7:0] junk;

        always @(posedge clk) begin
            if (cyc == 0) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            end else if (bus.mem_en && bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
            end
            pipe_v[0] <= !rst && bus.mem_en && !bus.mem_we;
            pipe_d[0] <= mem[bus.mem_addr];
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= !rst && pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            junk <= 8'($urandom);
        end
        assign bus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

        logic       chk_on;
        logic       if_acc, ls_acc;
        logic       m_act, m_last, m_id, m_we;
        logic [7:0] m_addr, m_wd, m_rdata;
        int         m_t;
        string      pfx;

        // Reference model: an access granted at cycle T strobes memory at T+1, is done at
        // T+2+LAT, and frees the port at T+3+LAT.
        initial begin
            int         d;
            logic       win, e_ifg, e_lsg, e_ifd, e_lsd, e_en, e_we, e_busy;
            logic [7:0] e_addr, e_wd;
            pfx    = $sformatf("lat%0d.", LAT);
            m_act  = 1'b0;
            m_last = 1'b1;
            m_rdata = 8'h00;
            m_id = 1'b0; m_we = 1'b0; m_addr = 8'h00; m_wd = 8'h00; m_t = 0;
            for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
            forever begin
                @(negedge clk);
                {win, e_ifg, e_lsg, e_ifd, e_lsd, e_en, e_we, e_busy} = '0;
                e_addr = 8'h00;
                e_wd   = 8'h00;
                d      = 0;
                if (m_act) begin
                    d      = cyc - m_t;
                    e_busy = 1'b1;
                    if (d == 1) begin
                        e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wd = m_wd;
                    end
                    if (d == 2 + LAT) begin
                        e_ifd = !m_id;
                        e_lsd = m_id;
                    end
                end else if (!rst && (bus.if_req || bus.ls_req)) begin
                    win   = (bus.if_req && bus.ls_req) ? !m_last : bus.ls_req;
                    e_ifg = !win;
                    e_lsg = win;
                end
                if_acc = bus.if_gnt;
                ls_acc = bus.ls_gnt;
                if (chk_on) begin
                    check_eq({pfx, "if_gnt"},   32'(bus.if_gnt),   32'(e_ifg));
                    check_eq({pfx, "ls_gnt"},   32'(bus.ls_gnt),   32'(e_lsg));
                    check_eq({pfx, "if_done"},  32'(bus.if_done),  32'(e_ifd));
                    check_eq({pfx, "ls_done"},  32'(bus.ls_done),  32'(e_lsd));
                    check_eq({pfx, "busy"},     32'(bus.busy),     32'(e_busy));
                    check_eq({pfx, "mem_en"},   32'(bus.mem_en),   32'(e_en));
                    check_eq({pfx, "mem_we"},   32'(bus.mem_we),   32'(e_we));
                    check_eq({pfx, "mem_addr"}, 32'(bus.mem_addr), 32'(e_addr));
                    // Write data of a fetch strobe carries no meaning; everything else is checked.
                    if (!(e_en && !m_id))
                        check_eq({pfx, "mem_wdata"}, 32'(bus.mem_wdata), 32'(e_wd));
                    check_eq({pfx, "rdata"},    32'(bus.rdata),    32'(m_rdata));
                end
                if (m_act && d == 1 && m_we) refmem[m_addr] = m_wd;
                if (m_act && !rst && d == 1 + LAT && !m_we) m_rdata = refmem[m_addr];
                if (m_act && d == 2 + LAT) m_act = 1'b0;
                if (e_ifg || e_lsg) begin
                    m_act  = 1'b1;
                    m_t    = cyc;
                    m_id   = win;
                    m_last = win;
                    m_we   = win && bus.ls_we;
                    m_addr = win ? bus.ls_addr : bus.if_addr;
                    m_wd   = win ? bus.ls_wdata : 8'h00;
                end
                if (rst) begin
                    m_act   = 1'b0;
                    m_last  = 1'b1;
                    m_rdata = 8'h00;
                end
            end
        end

        // Requesters: hold req until granted, then drop or immediately re-request new values.
        initial begin
            logic hold, rnd;
            chk_on       = 1'b0;
            rst          = 1'b1;
            bus.if_req   = 1'b1;
            bus.if_addr  = 8'h10;
            bus.ls_req   = 1'b0;
            bus.ls_we    = 1'b0;
            bus.ls_addr  = 8'h00;
            bus.ls_wdata = 8'h00;
            for (int k = 0; k < NCYC; k++) begin
                @(posedge clk);
                #1;
                hold = (k >= 10 && k < 40);
                rnd  = (k >= 85);
                if (rst && k > 0) rst = 1'b0;
                if (bus.if_req && if_acc) begin
                    if (hold || (rnd && $urandom_range(1) == 1)) bus.if_addr = 8'($urandom_range(15));
                    else bus.if_req = 1'b0;
                end
                if (bus.ls_req && ls_acc) begin
                    if (hold || (rnd && $urandom_range(1) == 1)) begin
                        bus.ls_we    = rnd ? 1'($urandom) : 1'b0;
                        bus.ls_addr  = 8'($urandom_range(15));
                        bus.ls_wdata = 8'($urandom);
                    end else begin
                        bus.ls_req = 1'b0;
                    end
                end
                case (k)
                    0:  chk_on = 1'b1;
                    8:  rst = 1'b1;
                    10: begin
                        bus.if_req = 1'b1; bus.if_addr = 8'h11;
                        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 8'h20;
                    end
                    60: begin
                        bus.ls_req = 1'b1; bus.ls_we = 1'b1;
                        bus.ls_addr = 8'h30; bus.ls_wdata = 8'h5C;
                    end
                    70: begin bus.if_req = 1'b1; bus.if_addr = 8'h12; end
                    72: rst = 1'b1;
                    75: begin bus.if_req = 1'b1; bus.if_addr = 8'h10; end
                    default: ;
                endcase
                if (rnd) begin
                    if ($urandom_range(299) == 0) rst = 1'b1;
                    if (!bus.if_req && $urandom_range(3) == 0) begin
                        bus.if_req  = 1'b1;
                        bus.if_addr = 8'($urandom_range(15));
                    end
                    if (!bus.ls_req && $urandom_range(3) == 0) begin
                        bus.ls_req   = 1'b1;
                        bus.ls_we    = 1'($urandom);
                        bus.ls_addr  = 8'($urandom_range(15));
                        bus.ls_wdata = 8'($urandom);
                    end
                end
            end
            @(posedge clk);
            #1;
            rst        = 1'b0;
            bus.if_req = 1'b0;
            bus.ls_req = 1'b0;
        end
    end

    initial begin
        repeat (NCYC + 100) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
